bin2bcd_seq: RTL and testbench

- Sequential double-dabble converter: binary value in, decimal digits out, one bit per clock.
- Sits directly upstream of the six-digit seven-segment driver in the accelerometer display path.
- Feeds the per-digit segment decoders with ready-made BCD nibbles, so the display path needs no wide combinational divide/modulo chains.
- Flags values that do not fit in the displayed digits.

---
 rtl/bin2bcd_pkg.sv | 20 ++
 rtl/bcd_add3_nibble.sv | 11 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants, state type and helpers for bin2bcd_seq
package bin2bcd_pkg;

  localparam int BCD_NIBBLE_W   = 4;
  localparam int ADD3_THRESHOLD = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Largest value that fits in the given number of decimal digits.
  function automatic longint unsigned max_pow10_minus1(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// rtl/bcd_add3_nibble.sv - double-dabble digit correction: add 3 when the nibble is 5 or more
module bcd_add3_nibble
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] i_nib,
  output logic [BCD_NIBBLE_W-1:0] o_nib
);

  assign o_nib = (i_nib >= BCD_NIBBLE_W'(ADD3_THRESHOLD)) ? i_nib + BCD_NIBBLE_W'(3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per clock
// Optional macro BIN2BCD_SATURATE_EN: overflowing results show as all nines.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W       = 26,
  parameter int DIGITS      = 6,
  parameter int FULL_DIGITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BIN_W-1:0]             bin_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                         out_valid,
  output logic                         overflow,
  output logic                         busy
);

  localparam int ACC_W = BCD_NIBBLE_W * FULL_DIGITS;
  localparam int OUT_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (FULL_DIGITS < DIGITS) begin : g_bad_digits
    $error("bin2bcd_seq: FULL_DIGITS must be >= DIGITS");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_sreg;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_out_valid;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_shift;
  logic [OUT_W-1:0]   w_bcd_next;
  logic               w_ovf;
  logic               w_accept;
  logic               w_last;

  for (genvar g = 0; g < FULL_DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .i_nib (r_acc[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .o_nib (w_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  assign w_acc_shift = {w_adj[ACC_W-2:0], r_sreg[BIN_W-1]};

  // The bit shifted out of the accumulator top also counts as lost digits.
  if (FULL_DIGITS > DIGITS) begin : g_ovf_wide
    assign w_ovf = w_adj[ACC_W-1] | (|w_acc_shift[ACC_W-1:OUT_W]);
  end else begin : g_ovf_narrow
    assign w_ovf = w_adj[ACC_W-1];
  end

`ifdef BIN2BCD_SATURATE_EN
  assign w_bcd_next = w_ovf ? {DIGITS{4'd9}} : w_acc_shift[OUT_W-1:0];
`else
  assign w_bcd_next = w_acc_shift[OUT_W-1:0];
`endif

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == SHIFT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_sreg <= bin_in;
        r_acc  <= '0;
        r_cnt  <= CNT_W'(BIN_W - 1);
      end else if (r_state == SHIFT) begin
        r_acc  <= w_acc_shift;
        r_sreg <= {r_sreg[BIN_W-2:0], 1'b0};
        r_cnt  <= r_cnt - 1'b1;
        if (w_last) begin
          r_bcd       <= w_bcd_next;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign bcd_out   = r_bcd;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int BIN_W  = 26;
  localparam int DIGITS = 6;

  logic                  clk;
  logic                  rst_n;
  logic [BIN_W-1:0]      bin_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  out_valid;
  logic                  overflow;
  logic                  busy;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .FULL_DIGITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;
    int                  due;
    longint unsigned     val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_ov   = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference built from divide/modulo, independent of double-dabble.
  function automatic exp_t model(input longint unsigned v, input int due);
    exp_t e;
    longint unsigned t;
    t = v;
    e.bcd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      e.bcd[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.ovf = (v > max_pow10_minus1(DIGITS));
`ifdef BIN2BCD_SATURATE_EN
    if (e.ovf) e.bcd = {DIGITS{4'd9}};
`endif
    e.due = due;
    e.val = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      n_ov++;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bcd_%0d", e.val), 32'(bcd_out), 32'(e.bcd));
        check($sformatf("ovf_%0d", e.val), 32'(overflow), 32'(e.ovf));
        check($sformatf("latency_%0d", e.val), 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send(input longint unsigned v);
    @(negedge clk);
    bin_in   = BIN_W'(v);
    in_valid = 1'b1;
    check("in_ready_at_send", 32'(in_ready), 32'd1);
    sb.push_back(model(v, cyc + 1 + BIN_W));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * BIN_W && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int ov_snap;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(123456);
    check("busy_during_shift", 32'(busy), 32'd1);
    check("in_ready_during_shift", 32'(in_ready), 32'd0);
    wait_drain();
    send(0);               wait_drain();
    send(999999);          wait_drain();
    send(1000000);         wait_drain();
    send(64'd67108863);    wait_drain();

    // Back-to-back: 7 held during busy must be ignored, then taken in the out_valid cycle.
    @(negedge clk);
    bin_in   = BIN_W'(42);
    in_valid = 1'b1;
    sb.push_back(model(42, cyc + 1 + BIN_W));
    @(negedge clk);
    bin_in = BIN_W'(7);
    check("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 2 * BIN_W && !in_ready; i++) @(negedge clk);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    check("b2b_out_valid_on_accept", 32'(out_valid), 32'd1);
    sb.push_back(model(7, cyc + 1 + BIN_W));
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a conversion.
    send(555555);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    ov_snap = n_ov;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIN_W) @(negedge clk);
    check("no_out_valid_after_rst", 32'(n_ov), 32'(ov_snap));
    send(314159);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
